dequeue_req_scheduler: RTL and testbench

Round-robin scheduler directly upstream of queue_manager. Tracks which queues have doorbelled work and issues dequeue requests with unique tags. It consumes dequeue responses and forwards non-empty operations to the TX engine. Queues reported empty or errored are deactivated until the next doorbell.

---
 rtl/dequeue_sched_pkg.sv | 39 +++
 rtl/dequeue_req_scheduler_if.sv | 48 ++++
 rtl/dequeue_rr_select.sv | 26 ++
 rtl/dequeue_req_scheduler.sv | 162 ++++++++++++++++
 tb/tb_dequeue_req_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dequeue_sched_pkg.sv
// Shared types, sizes and helpers for the dequeue request scheduler.
package dequeue_sched_pkg;

  localparam int unsigned QUEUE_INDEX_WIDTH = 4;
  localparam int unsigned REQ_TAG_WIDTH     = 3;
  localparam int unsigned OP_TAG_WIDTH      = 8;
  localparam int unsigned NUM_QUEUES        = 2 ** QUEUE_INDEX_WIDTH;
  localparam int unsigned NUM_TAGS          = 2 ** REQ_TAG_WIDTH;

  typedef logic [QUEUE_INDEX_WIDTH-1:0] queue_idx_t;
  typedef logic [REQ_TAG_WIDTH-1:0]     req_tag_t;
  typedef logic [OP_TAG_WIDTH-1:0]      op_tag_t;
  typedef logic [NUM_QUEUES-1:0]        queue_mask_t;
  typedef logic [NUM_TAGS-1:0]          tag_mask_t;

  typedef struct packed {
    queue_idx_t queue;
    op_tag_t    op_tag;
  } tx_op_t;

  typedef struct packed {
    logic       found;
    queue_idx_t idx;
  } lowest_t;

  // Index of the lowest set bit; tag masks are zero-extended to queue width by callers.
  function automatic lowest_t lowest_set(input queue_mask_t vec);
    lowest_t res;
    res = '0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res.found = 1'b1;
        res.idx   = queue_idx_t'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dequeue_req_scheduler_if.sv
// Stream bundle between the scheduler (master side) and its doorbell/queue-manager/TX peers.
interface dequeue_req_scheduler_if;
  import dequeue_sched_pkg::*;

  queue_idx_t s_axis_doorbell_queue;
  logic       s_axis_doorbell_valid;

  queue_idx_t m_axis_dequeue_req_queue;
  req_tag_t   m_axis_dequeue_req_tag;
  logic       m_axis_dequeue_req_valid;
  logic       m_axis_dequeue_req_ready;

  queue_idx_t s_axis_dequeue_resp_queue;
  req_tag_t   s_axis_dequeue_resp_tag;
  op_tag_t    s_axis_dequeue_resp_op_tag;
  logic       s_axis_dequeue_resp_empty;
  logic       s_axis_dequeue_resp_error;
  logic       s_axis_dequeue_resp_valid;
  logic       s_axis_dequeue_resp_ready;

  queue_idx_t m_axis_tx_op_queue;
  op_tag_t    m_axis_tx_op_tag;
  logic       m_axis_tx_op_valid;
  logic       m_axis_tx_op_ready;

  modport master (
    input  s_axis_doorbell_queue, s_axis_doorbell_valid,
    output m_axis_dequeue_req_queue, m_axis_dequeue_req_tag, m_axis_dequeue_req_valid,
    input  m_axis_dequeue_req_ready,
    input  s_axis_dequeue_resp_queue, s_axis_dequeue_resp_tag, s_axis_dequeue_resp_op_tag,
    input  s_axis_dequeue_resp_empty, s_axis_dequeue_resp_error, s_axis_dequeue_resp_valid,
    output s_axis_dequeue_resp_ready,
    output m_axis_tx_op_queue, m_axis_tx_op_tag, m_axis_tx_op_valid,
    input  m_axis_tx_op_ready
  );

  modport slave (
    output s_axis_doorbell_queue, s_axis_doorbell_valid,
    input  m_axis_dequeue_req_queue, m_axis_dequeue_req_tag, m_axis_dequeue_req_valid,
    output m_axis_dequeue_req_ready,
    output s_axis_dequeue_resp_queue, s_axis_dequeue_resp_tag, s_axis_dequeue_resp_op_tag,
    output s_axis_dequeue_resp_empty, s_axis_dequeue_resp_error, s_axis_dequeue_resp_valid,
    input  s_axis_dequeue_resp_ready,
    input  m_axis_tx_op_queue, m_axis_tx_op_tag, m_axis_tx_op_valid,
    output m_axis_tx_op_ready
  );

endinterface

// File: rtl/dequeue_rr_select.sv
// Rotating-mask priority encoder: first eligible queue at or after rr_ptr, wrapping.
module dequeue_rr_select
  import dequeue_sched_pkg::*;
(
  input  queue_mask_t eligible,
  input  queue_idx_t  rr_ptr,
  output queue_idx_t  sel,
  output logic        sel_valid
);

  queue_mask_t rotated;
  lowest_t     first;

  // Bit i of rotated is queue (rr_ptr + i); index arithmetic wraps at queue width.
  always_comb begin
    rotated = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      rotated[i] = eligible[queue_idx_t'(i) + rr_ptr];
    end
  end

  assign first     = lowest_set(rotated);
  assign sel       = first.idx + rr_ptr;
  assign sel_valid = first.found;

endmodule

// File: rtl/dequeue_req_scheduler.sv
// Round-robin dequeue request scheduler with tag tracking and TX op forwarding.
// Optional statistics counters are built only when DEQ_SCHED_STATS_EN is defined.
module dequeue_req_scheduler
  import dequeue_sched_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  dequeue_req_scheduler_if.master   bus,
  output logic [31:0]               stat_req_count,
  output logic [31:0]               stat_empty_count,
  output logic [15:0]               stat_error_count
);

  queue_mask_t active_q, active_d;
  queue_mask_t inflight_q, inflight_d;
  tag_mask_t   tag_busy_q, tag_busy_d;
  queue_idx_t  tag_queue_q [NUM_TAGS];
  queue_idx_t  rr_ptr_q, rr_ptr_d;
  logic        req_valid_q, req_valid_d;
  queue_idx_t  req_queue_q, req_queue_d;
  req_tag_t    req_tag_q, req_tag_d;
  logic        tx_valid_q, tx_valid_d;
  tx_op_t      tx_op_q, tx_op_d;

  queue_mask_t eligible;
  queue_idx_t  sel;
  logic        sel_valid;
  tag_mask_t   free_mask;
  lowest_t     free_tag;
  logic        tag_avail;
  req_tag_t    alloc_tag;
  logic        load, req_fire, resp_fire, resp_tag_ok, resp_drop, resp_forward;

  assign eligible = active_q & ~inflight_q;

  dequeue_rr_select u_rr_select (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .sel       (sel),
    .sel_valid (sel_valid)
  );

  // Allocation uses the registered (pre-free) bitmap; a tag freed this cycle is reusable next cycle.
  assign free_mask = ~tag_busy_q;
  assign free_tag  = lowest_set(queue_mask_t'(free_mask));
  assign tag_avail = free_tag.found & ((free_tag.idx >> REQ_TAG_WIDTH) == '0);
  assign alloc_tag = req_tag_t'(free_tag.idx);

  assign req_fire = req_valid_q & bus.m_axis_dequeue_req_ready;
  assign load     = enable & sel_valid & tag_avail & (~req_valid_q | bus.m_axis_dequeue_req_ready);

  assign bus.s_axis_dequeue_resp_ready = ~tx_valid_q | bus.m_axis_tx_op_ready;
  assign resp_fire    = bus.s_axis_dequeue_resp_valid & bus.s_axis_dequeue_resp_ready;
  assign resp_tag_ok  = tag_busy_q[bus.s_axis_dequeue_resp_tag];
  assign resp_drop    = bus.s_axis_dequeue_resp_empty | bus.s_axis_dequeue_resp_error;
  assign resp_forward = resp_fire & resp_tag_ok & ~resp_drop;

  always_comb begin
    active_d    = active_q;
    inflight_d  = inflight_q;
    tag_busy_d  = tag_busy_q;
    rr_ptr_d    = rr_ptr_q;
    req_valid_d = req_valid_q;
    req_queue_d = req_queue_q;
    req_tag_d   = req_tag_q;
    tx_valid_d  = tx_valid_q;
    tx_op_d     = tx_op_q;

    if (resp_fire && resp_tag_ok) begin
      tag_busy_d[bus.s_axis_dequeue_resp_tag]              = 1'b0;
      inflight_d[tag_queue_q[bus.s_axis_dequeue_resp_tag]] = 1'b0;
      if (resp_drop) active_d[bus.s_axis_dequeue_resp_queue] = 1'b0;
    end
    // Applied after the empty/error clear so a same-cycle doorbell keeps the queue active.
    if (bus.s_axis_doorbell_valid) active_d[bus.s_axis_doorbell_queue] = 1'b1;

    if (load) begin
      inflight_d[sel]       = 1'b1;
      tag_busy_d[alloc_tag] = 1'b1;
      rr_ptr_d              = sel + queue_idx_t'(1);
      req_valid_d           = 1'b1;
      req_queue_d           = sel;
      req_tag_d             = alloc_tag;
    end else if (req_fire) begin
      req_valid_d = 1'b0;
    end

    if (resp_forward) begin
      tx_valid_d     = 1'b1;
      tx_op_d.queue  = bus.s_axis_dequeue_resp_queue;
      tx_op_d.op_tag = bus.s_axis_dequeue_resp_op_tag;
    end else if (bus.m_axis_tx_op_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= '0;
      inflight_q  <= '0;
      tag_busy_q  <= '0;
      rr_ptr_q    <= '0;
      req_valid_q <= 1'b0;
      req_queue_q <= '0;
      req_tag_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_op_q     <= '0;
      for (int i = 0; i < NUM_TAGS; i++) tag_queue_q[i] <= '0;
    end else begin
      active_q    <= active_d;
      inflight_q  <= inflight_d;
      tag_busy_q  <= tag_busy_d;
      rr_ptr_q    <= rr_ptr_d;
      req_valid_q <= req_valid_d;
      req_queue_q <= req_queue_d;
      req_tag_q   <= req_tag_d;
      tx_valid_q  <= tx_valid_d;
      tx_op_q     <= tx_op_d;
      if (load) tag_queue_q[alloc_tag] <= sel;
    end
  end

  assign bus.m_axis_dequeue_req_queue = req_queue_q;
  assign bus.m_axis_dequeue_req_tag   = req_tag_q;
  assign bus.m_axis_dequeue_req_valid = req_valid_q;
  assign bus.m_axis_tx_op_queue       = tx_op_q.queue;
  assign bus.m_axis_tx_op_tag         = tx_op_q.op_tag;
  assign bus.m_axis_tx_op_valid       = tx_valid_q;

`ifdef DEQ_SCHED_STATS_EN
  logic [31:0] req_cnt_q, empty_cnt_q;
  logic [15:0] err_cnt_q;
  logic        err_event;

  // Bad-tag responses count as errors; only tracked tags can report an empty queue.
  assign err_event = resp_fire & (bus.s_axis_dequeue_resp_error | ~resp_tag_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt_q   <= '0;
      empty_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (req_fire) req_cnt_q <= req_cnt_q + 32'd1;
      if (resp_fire && resp_tag_ok && bus.s_axis_dequeue_resp_empty) begin
        empty_cnt_q <= empty_cnt_q + 32'd1;
      end
      if (err_event && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign stat_req_count   = req_cnt_q;
  assign stat_empty_count = empty_cnt_q;
  assign stat_error_count = err_cnt_q;
`else
  assign stat_req_count   = '0;
  assign stat_empty_count = '0;
  assign stat_error_count = '0;
`endif

endmodule

// File: tb/tb_dequeue_req_scheduler.sv
// Self-checking bench: directed scenarios then randomized traffic against a cycle-level reference model.
module tb_dequeue_req_scheduler;
  import dequeue_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] stat_req_count, stat_empty_count;
  logic [15:0] stat_error_count;

  dequeue_req_scheduler_if bus ();

  dequeue_req_scheduler dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .bus              (bus),
    .stat_req_count   (stat_req_count),
    .stat_empty_count (stat_empty_count),
    .stat_error_count (stat_error_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit     m_active [NUM_QUEUES];
  bit     m_inflight [NUM_QUEUES];
  bit     m_busy [NUM_TAGS];
  int     m_tagq [NUM_TAGS];
  int     m_rr, m_rq, m_rt, m_tq, m_top;
  bit     m_rv, m_tv;
  longint m_sreq, m_sempty, m_serr;

  int pend_q[$], pend_t[$];   // requests the bench's queue manager still owes a response for
  int obs_q[$], obs_t[$];     // request handshakes as seen on the DUT pins
  bit resp_accepted;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] stat_exp(input longint v, input longint mask);
`ifdef DEQ_SCHED_STATS_EN
    return 64'(v & mask);
`else
    return 64'(v & mask & 0);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_QUEUES; i++) begin m_active[i] = 0; m_inflight[i] = 0; end
    for (int i = 0; i < NUM_TAGS; i++) begin m_busy[i] = 0; m_tagq[i] = 0; end
    m_rr = 0; m_rv = 0; m_rq = 0; m_rt = 0; m_tv = 0; m_tq = 0; m_top = 0;
    m_sreq = 0; m_sempty = 0; m_serr = 0;
    pend_q.delete(); pend_t.delete(); obs_q.delete(); obs_t.delete();
  endtask

  // Advance the model across one rising edge, from the inputs currently driven.
  task automatic model_step();
    bit rready, rfire, ok, drop;
    int sel, tag, rtag, rq;
    rtag   = int'(bus.s_axis_dequeue_resp_tag);
    rq     = int'(bus.s_axis_dequeue_resp_queue);
    rready = !m_tv || bus.m_axis_tx_op_ready;
    check("resp_ready", bus.s_axis_dequeue_resp_ready, rready);
    sel = -1;
    for (int k = 0; k < NUM_QUEUES; k++) begin
      int q = (m_rr + k) % NUM_QUEUES;
      if (sel < 0 && m_active[q] && !m_inflight[q]) sel = q;
    end
    tag = -1;
    for (int i = 0; i < NUM_TAGS; i++) if (tag < 0 && !m_busy[i]) tag = i;
    rfire = bus.s_axis_dequeue_resp_valid && rready;
    resp_accepted = rfire;
    ok   = rfire && m_busy[rtag];
    drop = bus.s_axis_dequeue_resp_empty || bus.s_axis_dequeue_resp_error;
    if (m_rv && bus.m_axis_dequeue_req_ready) begin
      pend_q.push_back(m_rq); pend_t.push_back(m_rt); m_sreq++;
    end
    if (ok) begin
      m_busy[rtag] = 0;
      m_inflight[m_tagq[rtag]] = 0;
      if (drop) m_active[rq] = 0;
      if (bus.s_axis_dequeue_resp_empty) m_sempty++;
    end
    if (rfire && (!ok || bus.s_axis_dequeue_resp_error) && m_serr < 65535) m_serr++;
    if (bus.s_axis_doorbell_valid) m_active[int'(bus.s_axis_doorbell_queue)] = 1;
    if (enable && sel >= 0 && tag >= 0 && (!m_rv || bus.m_axis_dequeue_req_ready)) begin
      m_inflight[sel] = 1; m_busy[tag] = 1; m_tagq[tag] = sel;
      m_rr = (sel + 1) % NUM_QUEUES;
      m_rv = 1; m_rq = sel; m_rt = tag;
    end else if (m_rv && bus.m_axis_dequeue_req_ready) begin
      m_rv = 0;
    end
    if (ok && !drop) begin
      m_tv = 1; m_tq = rq; m_top = int'(bus.s_axis_dequeue_resp_op_tag);
    end else if (bus.m_axis_tx_op_ready) begin
      m_tv = 0;
    end
  endtask

  task automatic check_outputs();
    check("req_valid", bus.m_axis_dequeue_req_valid, m_rv);
    if (m_rv) begin
      check("req_queue", bus.m_axis_dequeue_req_queue, m_rq);
      check("req_tag", bus.m_axis_dequeue_req_tag, m_rt);
    end
    check("tx_valid", bus.m_axis_tx_op_valid, m_tv);
    if (m_tv) begin
      check("tx_queue", bus.m_axis_tx_op_queue, m_tq);
      check("tx_op_tag", bus.m_axis_tx_op_tag, m_top);
    end
    check("stat_req", stat_req_count, stat_exp(m_sreq, 64'hFFFF_FFFF));
    check("stat_empty", stat_empty_count, stat_exp(m_sempty, 64'hFFFF_FFFF));
    check("stat_error", stat_error_count, stat_exp(m_serr, 64'hFFFF));
  endtask

  // One clock: model + DUT advance, outputs compared #1 after the edge, strobes dropped.
  task automatic cycle();
    @(negedge clk);
    if (bus.m_axis_dequeue_req_valid && bus.m_axis_dequeue_req_ready) begin
      obs_q.push_back(int'(bus.m_axis_dequeue_req_queue));
      obs_t.push_back(int'(bus.m_axis_dequeue_req_tag));
    end
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    bus.s_axis_doorbell_valid = 1'b0;
    if (resp_accepted) bus.s_axis_dequeue_resp_valid = 1'b0;
  endtask

  task automatic doorbell(input int q);
    bus.s_axis_doorbell_queue = queue_idx_t'(q);
    bus.s_axis_doorbell_valid = 1'b1;
  endtask

  task automatic respond(input int q, input int t, input int op, input bit empty, input bit err);
    bus.s_axis_dequeue_resp_queue  = queue_idx_t'(q);
    bus.s_axis_dequeue_resp_tag    = req_tag_t'(t);
    bus.s_axis_dequeue_resp_op_tag = op_tag_t'(op);
    bus.s_axis_dequeue_resp_empty  = empty;
    bus.s_axis_dequeue_resp_error  = err;
    bus.s_axis_dequeue_resp_valid  = 1'b1;
  endtask

  // Answer the oldest outstanding request carrying tag t.
  task automatic respond_tag(input int t, input int op, input bit empty);
    for (int i = 0; i < pend_t.size(); i++) begin
      if (pend_t[i] == t) begin
        respond(pend_q[i], t, op, empty, 1'b0);
        pend_q.delete(i); pend_t.delete(i);
        return;
      end
    end
    check("respond_tag_found", 64'(t), 64'hFFFF);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.s_axis_doorbell_valid = 1'b0;
    bus.s_axis_dequeue_resp_valid = 1'b0;
    #1;
    model_reset();
    check("rst_req_valid", bus.m_axis_dequeue_req_valid, 0);
    check("rst_req_queue", bus.m_axis_dequeue_req_queue, 0);
    check("rst_req_tag", bus.m_axis_dequeue_req_tag, 0);
    check("rst_tx_valid", bus.m_axis_tx_op_valid, 0);
    check("rst_tx_op", {bus.m_axis_tx_op_queue, bus.m_axis_tx_op_tag}, 0);
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    bus.s_axis_doorbell_queue = '0;
    bus.s_axis_doorbell_valid = 1'b0;
    bus.m_axis_dequeue_req_ready = 1'b1;
    bus.s_axis_dequeue_resp_queue = '0;
    bus.s_axis_dequeue_resp_tag = '0;
    bus.s_axis_dequeue_resp_op_tag = '0;
    bus.s_axis_dequeue_resp_empty = 1'b0;
    bus.s_axis_dequeue_resp_error = 1'b0;
    bus.s_axis_dequeue_resp_valid = 1'b0;
    bus.m_axis_tx_op_ready = 1'b1;
    do_reset();
    enable = 1'b1;

    // Single queue: 2-cycle doorbell latency, op forwarding, re-request.
    doorbell(3);
    cycle();
    check("tp1_no_early_req", bus.m_axis_dequeue_req_valid, 0);
    cycle();
    check("tp1_req_valid", bus.m_axis_dequeue_req_valid, 1);
    check("tp1_req_queue", bus.m_axis_dequeue_req_queue, 3);
    check("tp1_req_tag", bus.m_axis_dequeue_req_tag, 0);
    cycle();
    respond_tag(0, 'h5A, 1'b0);
    cycle();
    check("tp1_tx_valid", bus.m_axis_tx_op_valid, 1);
    check("tp1_tx_op", {bus.m_axis_tx_op_queue, bus.m_axis_tx_op_tag}, {4'd3, 8'h5A});
    cycle();
    check("tp1_rereq_queue", bus.m_axis_dequeue_req_queue, 3);

    // Round-robin order with wrap.
    do_reset();
    doorbell(1);  cycle();
    doorbell(5);  cycle();
    doorbell(14); cycle();
    repeat (3) cycle();
    respond_tag(0, 'h11, 1'b0);
    repeat (3) cycle();
    check("tp2_count", obs_q.size(), 4);
    if (obs_q.size() >= 4) begin
      check("tp2_order0", obs_q[0], 1);
      check("tp2_order1", obs_q[1], 5);
      check("tp2_order2", obs_q[2], 14);
      check("tp2_order3", obs_q[3], 1);
    end

    // Tag exhaustion and reuse.
    do_reset();
    for (int q = 0; q < NUM_QUEUES; q++) begin doorbell(q); cycle(); end
    repeat (4) cycle();
    check("tp3_req_count", obs_t.size(), NUM_TAGS);
    for (int i = 0; i < obs_t.size() && i < NUM_TAGS; i++) check("tp3_tag_seq", obs_t[i], i);
    respond_tag(2, 'h22, 1'b0);
    cycle();
    check("tp3_no_same_cycle_reuse", bus.m_axis_dequeue_req_valid, 0);
    cycle();
    check("tp3_reuse_valid", bus.m_axis_dequeue_req_valid, 1);
    check("tp3_reuse_tag", bus.m_axis_dequeue_req_tag, 2);

    // Empty response racing a doorbell for the same queue.
    do_reset();
    doorbell(7);
    repeat (3) cycle();
    respond_tag(0, 'h07, 1'b1);
    doorbell(7);
    cycle();
    cycle();
    check("tp4_rereq_valid", bus.m_axis_dequeue_req_valid, 1);
    check("tp4_rereq_queue", bus.m_axis_dequeue_req_queue, 7);
    cycle();
    respond_tag(0, 'h07, 1'b1);
    repeat (6) cycle();
    check("tp4_no_rereq", obs_q.size(), 2);

    // Async reset while a request is held.
    do_reset();
    bus.m_axis_dequeue_req_ready = 1'b0;
    doorbell(4);
    repeat (3) cycle();
    check("tp6_held_valid", bus.m_axis_dequeue_req_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("tp6_async_req_valid", bus.m_axis_dequeue_req_valid, 0);
    check("tp6_async_tx_valid", bus.m_axis_tx_op_valid, 0);
    bus.m_axis_dequeue_req_ready = 1'b1;
    do_reset();
    repeat (5) cycle();
    check("tp6_no_req_after_reset", obs_q.size(), 0);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      enable = ($urandom_range(7) != 0);
      bus.m_axis_dequeue_req_ready = ($urandom_range(3) != 0);
      bus.m_axis_tx_op_ready = ($urandom_range(2) != 0);
      if ($urandom_range(3) == 0) doorbell(int'($urandom_range(NUM_QUEUES - 1)));
      if (!bus.s_axis_dequeue_resp_valid) begin
        if ($urandom_range(39) == 0) begin
          for (int t = 0; t < NUM_TAGS; t++) begin
            if (!m_busy[t] && !bus.s_axis_dequeue_resp_valid) begin
              respond(int'($urandom_range(NUM_QUEUES - 1)), t, 0, 1'b0, 1'b0);
            end
          end
        end else if (pend_q.size() > 0 && $urandom_range(2) == 0) begin
          int i = int'($urandom_range(pend_q.size() - 1));
          int r = int'($urandom_range(9));
          respond(pend_q[i], pend_t[i], int'($urandom_range(255)), r == 0, r == 1);
          pend_q.delete(i); pend_t.delete(i);
        end
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
